data_mem_stage: RTL and testbench

//  MEM-stage data memory of Pipe_CPU_1: byte-addressed RAM serving lw/lh/lb/sw/sh/sb from EX/MEM.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/dm_lane_align.sv | 46 ++++
 rtl/data_mem_stage.sv | 168 ++++++++++++++++
 tb/tb_data_mem_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Brief    : Shared encodings and helpers for the MEM-stage data memory.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Reserved size reports 4 so bounds checks stay conservative.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dm_lane_align
// Brief    : Store byte enables/lane steering and load extraction/extension.
// Revision : 1.0 - initial release
// ============================================================================
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rbytes,
    output logic [3:0]  o_be,
    output logic [31:0] o_wbytes,
    output logic [31:0] o_ldata
);

    // Byte k of the store data always lands at address+k.
    assign o_wbytes = i_wdata;

    always_comb begin
        o_be    = 4'b0000;
        o_ldata = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001;
                o_ldata = {{24{i_sign & i_rbytes[7]}}, i_rbytes[7:0]};
            end
            SZ_HALF: begin
                o_be    = 4'b0011;
                o_ldata = {{16{i_sign & i_rbytes[15]}}, i_rbytes[15:0]};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_ldata = i_rbytes;
            end
            default: begin
                o_be    = 4'b0000;
                o_ldata = 32'h0000_0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_stage
// Brief    : MEM-stage byte RAM, multi-cycle valid/ready access, stalls pipe.
//            Define DM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_stage
    import dm_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              resp_valid_o,
    output logic              err_o,
    output logic              stall_o
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]         r_state, w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we, r_sign, r_err;
    logic [1:0]         r_size;
    logic [ADDR_W-1:0]  r_addr, w_eff_addr;
    logic [31:0]        r_wdata, r_rdata;
    logic               w_accept, w_access, w_misalign, w_oob, w_err;
    logic [ADDR_W:0]    w_last;
    logic [3:0]         w_be, w_inb;
    logic [31:0]        w_wbytes, w_rbytes, w_ldata;
    logic [ADDR_W-1:0]  w_idx [4];
    logic [7:0]         Mem [0:DEPTH-1];

    assign w_accept = req_valid_i && req_ready_o;
    assign w_access = (r_state == ST_BUSY) && (r_cnt == '0);

    // Bounds use the raw address with one extra bit so the top never wraps.
    assign w_last = {1'b0, r_addr} + (ADDR_W+1)'(size_bytes(r_size)) - (ADDR_W+1)'(1);
    assign w_oob  = w_last >= (ADDR_W+1)'(DEPTH);

`ifdef DM_MISALIGN_TRAP_EN
    assign w_misalign = ((r_size == SZ_HALF) && r_addr[0]) ||
                        ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
    assign w_eff_addr = r_addr;
`else
    assign w_misalign = 1'b0;
    always_comb begin
        w_eff_addr = r_addr;
        if (r_size == SZ_HALF) begin
            w_eff_addr[0] = 1'b0;
        end else if (r_size == SZ_WORD) begin
            w_eff_addr[1:0] = 2'b00;
        end
    end
`endif

    assign w_err = (r_size == SZ_RSVD) || w_misalign || w_oob;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_idx[k]              = w_eff_addr + ADDR_W'(k);
        assign w_inb[k]              = w_idx[k] < ADDR_W'(DEPTH);
        assign w_rbytes[8*k +: 8]    = w_inb[k] ? Mem[w_idx[k][c_IDX_W-1:0]] : 8'h00;
    end

    dm_lane_align u_align (
        .i_size   (r_size),
        .i_sign   (r_sign),
        .i_wdata  (r_wdata),
        .i_rbytes (w_rbytes),
        .o_be     (w_be),
        .o_wbytes (w_wbytes),
        .o_ldata  (w_ldata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_BUSY;
            ST_BUSY: if (r_cnt == '0) w_next = ST_RESP;
            ST_RESP: w_next = w_accept ? ST_BUSY : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        stall_o      = 1'b0;
        resp_valid_o = 1'b0;
        err_o        = 1'b0;
        case (r_state)
            ST_IDLE: req_ready_o = !rst_i;
            ST_BUSY: stall_o = 1'b1;
            ST_RESP: begin
                req_ready_o  = !rst_i;
                resp_valid_o = 1'b1;
                err_o        = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_sign  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= we_i;
                r_size  <= size_i;
                r_sign  <= sign_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_cnt   <= c_CNT_W'(LATENCY - 1);
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_access) begin
                r_err <= w_err;
                if (w_err) begin
                    r_rdata <= '0;
                end else if (!r_we) begin
                    r_rdata <= w_ldata;
                end
            end
        end
    end

    // Storage is not reset; a reset on the access edge cancels the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_access && r_we && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k] && w_inb[k]) begin
                    Mem[w_idx[k][c_IDX_W-1:0]] <= w_wbytes[8*k +: 8];
                end
            end
        end
    end

    assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_stage
// Brief    : Directed + randomized checks of data_mem_stage against a byte model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_mem_stage;

    localparam int DEPTH = 128;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_we, a_sign, a_resp, a_err, a_stall;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_sign, b_resp, b_err, b_stall;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;

    data_mem_stage #(.DEPTH(DEPTH), .LATENCY(LAT_A), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
        .we_i(a_we), .size_i(a_size), .sign_i(a_sign), .addr_i(a_addr),
        .wdata_i(a_wdata), .rdata_o(a_rdata), .resp_valid_o(a_resp),
        .err_o(a_err), .stall_o(a_stall)
    );

    data_mem_stage #(.DEPTH(DEPTH), .LATENCY(LAT_B), .ADDR_W(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .we_i(b_we), .size_i(b_size), .sign_i(b_sign), .addr_i(b_addr),
        .wdata_i(b_wdata), .rdata_o(b_rdata), .resp_valid_o(b_resp),
        .err_o(b_err), .stall_o(b_stall)
    );

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;
    logic [7:0]  model_mem [2][DEPTH];
    logic [31:0] exp_rdata [2];

    logic        o_ready, o_resp, o_err, o_stall;
    logic [31:0] o_rdata;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_resp  = sel ? b_resp  : a_resp;
    assign o_err   = sel ? b_err   : a_err;
    assign o_stall = sel ? b_stall : a_stall;
    assign o_rdata = sel ? b_rdata : a_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte array, little-endian, bounds on raw address, no wrap.
    task automatic model_access(input bit s, input bit we, input logic [1:0] size,
                                input bit sign, input logic [31:0] addr,
                                input logic [31:0] wd, output bit err,
                                output logic [31:0] rd);
        int nb;
        longint unsigned base;
        longint unsigned v;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err  = (size == 2'd3);
        base = 64'(addr);
        if (base + 64'(nb) - 1 >= 64'(DEPTH)) err = 1'b1;
`ifdef DM_MISALIGN_TRAP_EN
        if (base % 64'(nb) != 0) err = 1'b1;
`else
        base = base - (base % 64'(nb));
`endif
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) model_mem[s][base + 64'(i)] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v | (64'(model_mem[s][base + 64'(i)]) << (8*i));
                if (sign && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
                rd = v[31:0];
            end
        end
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [1:0] size,
                             input logic sign, input logic [31:0] addr, input logic [31:0] wd);
        if (!sel) begin
            a_valid = v; a_we = we; a_size = size; a_sign = sign; a_addr = addr; a_wdata = wd;
        end else begin
            b_valid = v; b_we = we; b_size = size; b_sign = sign; b_addr = addr; b_wdata = wd;
        end
    endtask

    task automatic mem_compare(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((sel ? dut1.Mem[i] : dut.Mem[i]) !== model_mem[sel][i]) n++;
        end
        chk(tag, 32'(n), 32'd0);
    endtask

    task automatic run_op(input bit we, input logic [1:0] size, input bit sign,
                          input logic [31:0] addr, input logic [31:0] wd, input string tag,
                          output logic [31:0] rd_seen, output logic err_seen);
        int lat;
        int guard;
        bit eerr;
        logic [31:0] erd;
        lat = sel ? LAT_B : LAT_A;
        @(negedge clk);
        drive_req(1'b1, we, size, sign, addr, wd);
        guard = 0;
        while (!o_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "/ready"}, 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        model_access(sel, we, size, sign, addr, wd, eerr, erd);
        if (eerr) exp_rdata[sel] = 32'h0;
        else if (!we) exp_rdata[sel] = erd;
        for (int e = 0; e < lat; e++) begin
            chk({tag, "/busy"}, {29'd0, o_stall, o_resp, o_ready}, 32'b100);
            @(posedge clk);
            #1;
        end
        chk({tag, "/resp"}, {28'd0, o_ready, o_stall, o_resp, o_err}, {28'd0, 1'b1, 1'b0, 1'b1, eerr});
        chk({tag, "/rdata"}, o_rdata, exp_rdata[sel]);
        rd_seen  = o_rdata;
        err_seen = o_err;
        @(posedge clk);
        #1;
        chk({tag, "/after"}, {28'd0, o_ready, o_stall, o_resp, o_err}, 32'b1000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] snap;
        logic [31:0] la [3];
        logic [1:0]  ls [3];
        bit          lsg [3];
        logic [31:0] exp_q [$];
        int          acc_edge [$];
        int          edge_no, nacc, nresp;
        bit          took, e6;
        logic [31:0] r6;

        rst = 1'b1;
        sel = 1'b0; drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        sel = 1'b1; drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        sel = 1'b0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        #12;
        chk("reset/a_outs", {28'd0, a_ready, a_resp, a_err, a_stall}, 32'd0);
        chk("reset/a_rdata", a_rdata, 32'h0);
        chk("reset/b_outs", {28'd0, b_ready, b_resp, b_err, b_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset/release_ready", {30'd0, a_ready, b_ready}, 32'b11);

        // Fill both memories through the front door so the model is known.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < DEPTH / 4; w++) run_op(1'b1, 2'd2, 1'b0, 32'(4*w), $urandom, "fill", rd, er);
            mem_compare("fill/mem");
        end
        sel = 1'b0;

        run_op(1'b1, 2'd2, 1'b0, 32'd8, 32'h11223344, "t1/sw", rd, er);
        chk("t1/sw_err", 32'(er), 32'd0);
        chk("t1/mem", {dut.Mem[11], dut.Mem[10], dut.Mem[9], dut.Mem[8]}, 32'h11223344);
        run_op(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, "t1/lw", rd, er);
        chk("t1/lw_val", rd, 32'h11223344);

        run_op(1'b1, 2'd2, 1'b0, 32'd8, 32'h80FF0000, "t2/sw", rd, er);
        run_op(1'b0, 2'd0, 1'b1, 32'd11, 32'h0, "t2/lb", rd, er);
        chk("t2/lb_val", rd, 32'hFFFFFF80);
        run_op(1'b0, 2'd0, 1'b0, 32'd11, 32'h0, "t2/lbu", rd, er);
        chk("t2/lbu_val", rd, 32'h00000080);
        run_op(1'b0, 2'd1, 1'b1, 32'd10, 32'h0, "t2/lh", rd, er);
        chk("t2/lh_val", rd, 32'hFFFF80FF);

        snap = {model_mem[0][127], model_mem[0][126], model_mem[0][125], model_mem[0][124]};
        run_op(1'b1, 2'd2, 1'b0, 32'd126, 32'hCAFEF00D, "t3/sw_oob", rd, er);
        chk("t3/sw_oob_err", 32'(er), 32'd1);
        chk("t3/mem_kept", {dut.Mem[127], dut.Mem[126], dut.Mem[125], dut.Mem[124]}, snap);
        run_op(1'b1, 2'd0, 1'b0, 32'd127, 32'h0000005A, "t3/sb", rd, er);
        chk("t3/sb_err", 32'(er), 32'd0);
        chk("t3/sb_mem", 32'(dut.Mem[127]), 32'h5A);
        run_op(1'b0, 2'd3, 1'b0, 32'd0, 32'h0, "t3/rsvd", rd, er);
        chk("t3/rsvd_err", 32'(er), 32'd1);

        snap = {model_mem[0][7], model_mem[0][6], model_mem[0][5], model_mem[0][4]};
        run_op(1'b0, 2'd2, 1'b0, 32'd6, 32'h0, "t4/lw6", rd, er);
`ifdef DM_MISALIGN_TRAP_EN
        chk("t4/trap_err", 32'(er), 32'd1);
        chk("t4/trap_rdata", rd, 32'h0);
`else
        chk("t4/align_err", 32'(er), 32'd0);
        chk("t4/align_rdata", rd, snap);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  rs;
            logic [31:0] ra;
            rs = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                             : 32'($urandom_range(0, 135));
            run_op(1'($urandom), rs, 1'($urandom), ra, $urandom, "rand", rd, er);
        end
        mem_compare("rand/mem");

        // Back-to-back loads on the LATENCY=1 instance with valid held high.
        sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ls[i]  = 2'($urandom_range(0, 2));
            la[i]  = 32'($urandom_range(0, 124));
            lsg[i] = 1'($urandom);
        end
        edge_no = 0; nacc = 0; nresp = 0;
        @(negedge clk);
        drive_req(1'b1, 1'b0, ls[0], lsg[0], la[0], 32'h0);
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (b_resp) begin
                nresp++;
                chk("b2b/stall_in_resp", 32'(b_stall), 32'd0);
                if (exp_q.size() > 0) begin
                    chk("b2b/rdata", b_rdata, exp_q.pop_front());
                    chk("b2b/latency", 32'(edge_no), 32'(acc_edge.pop_front() + LAT_B));
                end else begin
                    chk("b2b/spurious_resp", 32'(nresp), 32'(nacc));
                end
            end
            took = b_valid && b_ready;
            if (took) begin
                model_access(1'b1, 1'b0, ls[nacc], lsg[nacc], la[nacc], 32'h0, e6, r6);
                exp_q.push_back(e6 ? 32'h0 : r6);
                acc_edge.push_back(edge_no + 1);
                nacc++;
            end
            @(posedge clk);
            edge_no++;
            #1;
            if (took) begin
                if (nacc < 3) drive_req(1'b1, 1'b0, ls[nacc], lsg[nacc], la[nacc], 32'h0);
                else drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
            end
            @(negedge clk);
        end
        chk("b2b/accepts", 32'(nacc), 32'd3);
        chk("b2b/responses", 32'(nresp), 32'd3);

        // Reset in the middle of a store: outputs clear at once, no write.
        sel = 1'b0;
        run_op(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, "t5/pre_lw", rd, er);
        @(negedge clk);
        drive_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        chk("t5/busy", 32'(a_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5/rst_outs", {28'd0, a_ready, a_resp, a_err, a_stall}, 32'd0);
        chk("t5/rst_rdata", a_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        #1;
        mem_compare("t5/mem_untouched");
        chk("t5/ready_after", 32'(a_ready), 32'd1);
        run_op(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, "t5/lw0", rd, er);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
